// File: rtl/microcoded_processor_core_if.sv
// rtl/microcoded_processor_core_if.sv - control-store and host handshake bundle for the microcoded core.
// CYCLE_COUNT exists only when UCODE_CYCLE_COUNTER_EN is defined.
interface microcoded_processor_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic [3:0]            OPCODE;
  logic [DATA_WIDTH-1:0] DATA_IN_A;
  logic [DATA_WIDTH-1:0] DATA_IN_B;
  logic                  GO;
  logic                  JAM;
  logic [23:0]           MW;
  logic [7:0]            MICROADDRESS;
  logic [DATA_WIDTH-1:0] DATA_OUT;
  logic                  BUSY;
  logic                  DONE;
  logic                  ZERO_FLAG;
  logic                  CARRY_FLAG;
  logic                  STACK_ERR;
`ifdef UCODE_CYCLE_COUNTER_EN
  logic [15:0]           CYCLE_COUNT;
`endif

  modport master (
`ifdef UCODE_CYCLE_COUNTER_EN
    input  CYCLE_COUNT,
`endif
    output OPCODE, DATA_IN_A, DATA_IN_B, GO, JAM, MW,
    input  MICROADDRESS, DATA_OUT, BUSY, DONE, ZERO_FLAG, CARRY_FLAG, STACK_ERR
  );

  modport slave (
`ifdef UCODE_CYCLE_COUNTER_EN
    output CYCLE_COUNT,
`endif
    input  OPCODE, DATA_IN_A, DATA_IN_B, GO, JAM, MW,
    output MICROADDRESS, DATA_OUT, BUSY, DONE, ZERO_FLAG, CARRY_FLAG, STACK_ERR
  );
endinterface

// File: rtl/microcoded_processor_core.sv
// rtl/microcoded_processor_core.sv - microsequencer plus DATA_WIDTH datapath, one microword per cycle.
// Optional run-cycle counter on CYCLE_COUNT enabled by UCODE_CYCLE_COUNTER_EN.
module microcoded_processor_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                          SYSTEM_CLK,
  input  logic                          RESET,
  microcoded_processor_core_if.slave    bus
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] N_JMP = 4'd1, N_JZ = 4'd2, N_JC = 4'd3, N_CALL = 4'd4;
  localparam logic [3:0] N_RET = 4'd5, N_MAP = 4'd6, N_HALT = 4'd7;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [7:0]            upc_q, upc_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic                  z_q, z_d, c_q, c_d;
  logic [SPW-1:0]        sp_q, sp_d;
  logic [7:0]            stack_q [STACK_DEPTH];
  logic [7:0]            stack_d [STACK_DEPTH];
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
`ifdef UCODE_CYCLE_COUNTER_EN
  logic [15:0]           cnt_q, cnt_d;
`endif

  logic [3:0]            nxt, alu_op;
  logic [7:0]            br, upc_inc;
  logic                  ld_a, ld_b, a_alu, ld_out, upd;
  logic [DATA_WIDTH:0]   alu_ext;
  logic [DATA_WIDTH-1:0] alu_r;
  logic                  alu_c;
  logic [SPW-1:0]        sp_m1;
  logic [IW-1:0]         push_idx, pop_idx;
  logic                  unused_mw;

  assign nxt       = bus.MW[23:20];
  assign br        = bus.MW[19:12];
  assign alu_op    = bus.MW[11:8];
  assign ld_a      = bus.MW[7];
  assign ld_b      = bus.MW[6];
  assign a_alu     = bus.MW[5];
  assign ld_out    = bus.MW[4];
  assign upd       = bus.MW[3];
  assign unused_mw = ^bus.MW[2:0];
  assign upc_inc   = upc_q + 8'd1;
  assign sp_m1     = sp_q - SPW'(1);
  assign push_idx  = sp_q[IW-1:0];
  assign pop_idx   = sp_m1[IW-1:0];

  // Bit DATA_WIDTH of alu_ext carries the carry/borrow/shifted-out bit; zero for logic ops.
  always_comb begin
    alu_ext = {1'b0, a_q};
    case (alu_op)
      4'd1:    alu_ext = {1'b0, b_q};
      4'd2:    alu_ext = {1'b0, a_q} + {1'b0, b_q};
      4'd3:    alu_ext = {1'b0, a_q} - {1'b0, b_q};
      4'd4:    alu_ext = {1'b0, a_q & b_q};
      4'd5:    alu_ext = {1'b0, a_q | b_q};
      4'd6:    alu_ext = {1'b0, a_q ^ b_q};
      4'd7:    alu_ext = {1'b0, ~a_q};
      4'd8:    alu_ext = {a_q, 1'b0};
      4'd9:    alu_ext = {a_q[0], 1'b0, a_q[DATA_WIDTH-1:1]};
      4'd10:   alu_ext = {1'b0, a_q} + (DATA_WIDTH+1)'(1);
      4'd11:   alu_ext = {1'b0, a_q} - (DATA_WIDTH+1)'(1);
      default: alu_ext = {1'b0, a_q};
    endcase
    alu_r = alu_ext[DATA_WIDTH-1:0];
    alu_c = alu_ext[DATA_WIDTH];
  end

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    z_d     = z_q;
    c_d     = c_q;
    sp_d    = sp_q;
    stack_d = stack_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (bus.JAM) begin
      state_d = S_RUN;
      upc_d   = {bus.OPCODE, 4'b0000};
      sp_d    = '0;
    end else if (state_q == S_IDLE) begin
      upc_d = 8'h00;
      if (bus.GO) begin
        state_d = S_RUN;
        err_d   = 1'b0;
        sp_d    = '0;
      end
    end else begin
      if (a_alu)     a_d = alu_r;
      else if (ld_a) a_d = bus.DATA_IN_A;
      if (ld_b)      b_d = bus.DATA_IN_B;
      if (ld_out)    out_d = alu_r;
      if (upd) begin
        z_d = (alu_r == '0);
        c_d = alu_c;
      end
      // Branch conditions use z_q/c_q, the flags from before this microword.
      case (nxt)
        N_JMP: upc_d = br;
        N_JZ:  upc_d = z_q ? br : upc_inc;
        N_JC:  upc_d = c_q ? br : upc_inc;
        N_CALL: begin
          if (sp_q == SPW'(STACK_DEPTH)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            upc_d   = 8'h00;
          end else begin
            stack_d[push_idx] = upc_inc;
            sp_d              = sp_q + SPW'(1);
            upc_d             = br;
          end
        end
        N_RET: begin
          if (sp_q == '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            upc_d   = 8'h00;
          end else begin
            upc_d = stack_q[pop_idx];
            sp_d  = sp_m1;
          end
        end
        N_MAP: upc_d = {bus.OPCODE, 4'b0000};
        N_HALT: begin
          state_d = S_IDLE;
          upc_d   = 8'h00;
          done_d  = 1'b1;
        end
        default: upc_d = upc_inc;
      endcase
    end
    busy_d = (state_d == S_RUN);
  end

`ifdef UCODE_CYCLE_COUNTER_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_RUN && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    if (!bus.JAM && state_q == S_IDLE && bus.GO) cnt_d = 16'h0000;
  end
`endif

  always_ff @(posedge SYSTEM_CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      upc_q   <= 8'h00;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      sp_q    <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef UCODE_CYCLE_COUNTER_EN
      cnt_q   <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      z_q     <= z_d;
      c_q     <= c_d;
      sp_q    <= sp_d;
      stack_q <= stack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef UCODE_CYCLE_COUNTER_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.MICROADDRESS = upc_q;
  assign bus.DATA_OUT     = out_q;
  assign bus.BUSY         = busy_q;
  assign bus.DONE         = done_q;
  assign bus.ZERO_FLAG    = z_q;
  assign bus.CARRY_FLAG   = c_q;
  assign bus.STACK_ERR    = err_q;
`ifdef UCODE_CYCLE_COUNTER_EN
  assign bus.CYCLE_COUNT  = cnt_q;
`else
`endif
endmodule

// File: tb/tb_microcoded_processor_core.sv
// tb/tb_microcoded_processor_core.sv - 8-bit and 16-bit cores run in lockstep against a behavioural model.
// CYCLE_COUNT is compared when UCODE_CYCLE_COUNTER_EN is defined.
module tb_microcoded_processor_core;
  localparam int DEPTH = 4;
  localparam int LDA = 8'h80, LDB = 8'h40, AALU = 8'h20, LDOUT = 8'h10, UPD = 8'h08;

  logic        clk = 1'b0;
  logic        rst, go, jam;
  logic [3:0]  opcode;
  logic [15:0] a_in, b_in;
  logic [23:0] rom [256];
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  microcoded_processor_core_if #(.DATA_WIDTH(8))  if8 ();
  microcoded_processor_core_if #(.DATA_WIDTH(16)) if16 ();

  assign if8.OPCODE     = opcode;
  assign if8.DATA_IN_A  = a_in[7:0];
  assign if8.DATA_IN_B  = b_in[7:0];
  assign if8.GO         = go;
  assign if8.JAM        = jam;
  assign if8.MW         = rom[if8.MICROADDRESS];
  assign if16.OPCODE    = opcode;
  assign if16.DATA_IN_A = a_in;
  assign if16.DATA_IN_B = b_in;
  assign if16.GO        = go;
  assign if16.JAM       = jam;
  assign if16.MW        = rom[if16.MICROADDRESS];

  microcoded_processor_core #(.DATA_WIDTH(8), .STACK_DEPTH(DEPTH)) u_dut8 (
    .SYSTEM_CLK(clk), .RESET(rst), .bus(if8.slave));
  microcoded_processor_core #(.DATA_WIDTH(16), .STACK_DEPTH(DEPTH)) u_dut16 (
    .SYSTEM_CLK(clk), .RESET(rst), .bus(if16.slave));

  bit m_run [2], m_z [2], m_c [2], m_done [2], m_err [2];
  int m_upc [2], m_a [2], m_b [2], m_out [2], m_sp [2], m_cnt [2];
  int m_stk [2][DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] uw(input int nxt, input int br, input int alu, input int ctl);
    return {nxt[3:0], br[7:0], alu[3:0], ctl[7:0]};
  endfunction

  task automatic model_fault(input int i);
    m_err[i] = 1;
    m_run[i] = 0;
    m_upc[i] = 0;
  endtask

  task automatic model_step(input int i, input bit r);
    int w, mask, nxt, br, op, res, oa, ob;
    bit cy, oz, oc;
    logic [23:0] mwd;
    w = (i == 0) ? 8 : 16;
    mask = (1 << w) - 1;
    if (r) begin
      m_run[i] = 0; m_upc[i] = 0; m_a[i] = 0; m_b[i] = 0; m_out[i] = 0;
      m_z[i] = 0; m_c[i] = 0; m_sp[i] = 0; m_done[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
      return;
    end
    m_done[i] = 0;
    if (jam) begin
      if (m_run[i] && m_cnt[i] < 65535) m_cnt[i]++;
      m_run[i] = 1;
      m_upc[i] = opcode * 16;
      m_sp[i]  = 0;
      return;
    end
    if (!m_run[i]) begin
      if (go) begin
        m_run[i] = 1; m_upc[i] = 0; m_err[i] = 0; m_sp[i] = 0; m_cnt[i] = 0;
      end
      return;
    end
    if (m_cnt[i] < 65535) m_cnt[i]++;
    mwd = rom[m_upc[i]];
    nxt = int'(mwd[23:20]);
    br  = int'(mwd[19:12]);
    op  = int'(mwd[11:8]);
    oa = m_a[i]; ob = m_b[i]; oz = m_z[i]; oc = m_c[i];
    cy = 0;
    case (op)
      1:  res = ob;
      2:  begin res = oa + ob; cy = (res > mask); end
      3:  begin res = oa - ob; cy = (oa < ob); end
      4:  res = oa & ob;
      5:  res = oa | ob;
      6:  res = oa ^ ob;
      7:  res = ~oa;
      8:  begin res = oa * 2; cy = ((oa >> (w - 1)) & 1) != 0; end
      9:  begin res = oa / 2; cy = (oa & 1) != 0; end
      10: begin res = oa + 1; cy = (oa == mask); end
      11: begin res = oa - 1; cy = (oa == 0); end
      default: res = oa;
    endcase
    res = res & mask;
    if (mwd[5]) m_a[i] = res;
    else if (mwd[7]) m_a[i] = int'(a_in) & mask;
    if (mwd[6]) m_b[i] = int'(b_in) & mask;
    if (mwd[4]) m_out[i] = res;
    if (mwd[3]) begin
      m_z[i] = (res == 0);
      m_c[i] = cy;
    end
    case (nxt)
      1: m_upc[i] = br;
      2: m_upc[i] = oz ? br : (m_upc[i] + 1) % 256;
      3: m_upc[i] = oc ? br : (m_upc[i] + 1) % 256;
      4: if (m_sp[i] == DEPTH) model_fault(i);
         else begin
           m_stk[i][m_sp[i]] = (m_upc[i] + 1) % 256;
           m_sp[i]++;
           m_upc[i] = br;
         end
      5: if (m_sp[i] == 0) model_fault(i);
         else begin
           m_sp[i]--;
           m_upc[i] = m_stk[i][m_sp[i]];
         end
      6: m_upc[i] = opcode * 16;
      7: begin m_run[i] = 0; m_upc[i] = 0; m_done[i] = 1; end
      default: m_upc[i] = (m_upc[i] + 1) % 256;
    endcase
  endtask

  task automatic compare_all();
    check("upc8",  if8.MICROADDRESS, m_upc[0]);
    check("out8",  if8.DATA_OUT,     m_out[0]);
    check("busy8", if8.BUSY,         m_run[0]);
    check("done8", if8.DONE,         m_done[0]);
    check("z8",    if8.ZERO_FLAG,    m_z[0]);
    check("c8",    if8.CARRY_FLAG,   m_c[0]);
    check("err8",  if8.STACK_ERR,    m_err[0]);
    check("upc16", if16.MICROADDRESS, m_upc[1]);
    check("out16", if16.DATA_OUT,     m_out[1]);
    check("busy16", if16.BUSY,        m_run[1]);
    check("done16", if16.DONE,        m_done[1]);
    check("z16",   if16.ZERO_FLAG,    m_z[1]);
    check("c16",   if16.CARRY_FLAG,   m_c[1]);
    check("err16", if16.STACK_ERR,    m_err[1]);
`ifdef UCODE_CYCLE_COUNTER_EN
    check("cnt8",  if8.CYCLE_COUNT,  m_cnt[0]);
    check("cnt16", if16.CYCLE_COUNT, m_cnt[1]);
`endif
  endtask

  task automatic step(input bit r);
    rst = r;
    model_step(0, r);
    model_step(1, r);
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();
  endtask

  task automatic start();
    go = 1'b1;
    step(1'b0);
    go = 1'b0;
  endtask

  task automatic run_idle();
    for (int k = 0; k < 40 && (m_run[0] || m_run[1]); k++) step(1'b0);
    if (m_run[0] || m_run[1]) check("idle_timeout", 1, 0);
  endtask

  task automatic clear_rom();
    for (int k = 0; k < 256; k++) rom[k] = uw(7, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; jam = 1'b0; opcode = 4'd0; a_in = 16'h0; b_in = 16'h0;
    clear_rom();
    step(1'b1);

    // Build up some state, then reset mid-run.
    rom[0] = uw(0, 0, 0, LDA | LDB);
    rom[1] = uw(1, 1, 6, LDOUT | UPD);
    a_in = 16'hA5C3; b_in = 16'h0F0F;
    start(); step(1'b0); step(1'b0);
    step(1'b1);
    check("rst_out8", if8.DATA_OUT, 0);
    check("rst_upc8", if8.MICROADDRESS, 0);
    check("rst_busy8", if8.BUSY, 0);
    check("rst_out16", if16.DATA_OUT, 0);

    // ADD then HALT.
    clear_rom();
    rom[0] = uw(0, 0, 0, LDA | LDB);
    rom[1] = uw(7, 0, 2, LDOUT | UPD);
    a_in = 16'h00C8; b_in = 16'h0064;
    start();
    check("add_busy", if8.BUSY, 1);
    step(1'b0);
    check("add_done_early", if8.DONE, 0);
    step(1'b0);
    check("add_out8", if8.DATA_OUT, 8'h2C);
    check("add_c8", if8.CARRY_FLAG, 1);
    check("add_z8", if8.ZERO_FLAG, 0);
    check("add_done", if8.DONE, 1);
    check("add_out16", if16.DATA_OUT, 16'h012C);
    check("add_c16", if16.CARRY_FLAG, 0);
    step(1'b0);
    check("add_done_pulse", if8.DONE, 0);

    // JZ taken / not taken.
    clear_rom();
    rom[0] = uw(0, 0, 0, LDA | LDB);
    rom[1] = uw(0, 0, 3, UPD);
    rom[2] = uw(2, 8'h40, 0, 0);
    a_in = 16'h1234; b_in = 16'h1234;
    start(); step(1'b0); step(1'b0); step(1'b0);
    check("jz_upc16", if16.MICROADDRESS, 8'h40);
    check("jz_z16", if16.ZERO_FLAG, 1);
    run_idle();
    b_in = 16'h1235;
    start(); step(1'b0); step(1'b0); step(1'b0);
    check("jnz_upc16", if16.MICROADDRESS, 8'h03);
    check("jnz_z16", if16.ZERO_FLAG, 0);
    check("jnz_c16", if16.CARRY_FLAG, 1);
    run_idle();

    // MAP dispatch.
    clear_rom();
    rom[0] = uw(6, 0, 0, 0);
    opcode = 4'd5;
    start(); step(1'b0);
    check("map5", if8.MICROADDRESS, 8'h50);
    run_idle();
    opcode = 4'd15;
    start(); step(1'b0);
    check("map15", if16.MICROADDRESS, 8'hF0);
    run_idle();

    // CALL/RET pair.
    clear_rom();
    rom[0] = uw(4, 8'h10, 0, 0);
    rom[8'h10] = uw(5, 0, 0, 0);
    start(); step(1'b0);
    check("call_upc", if8.MICROADDRESS, 8'h10);
    step(1'b0);
    check("ret_upc", if8.MICROADDRESS, 8'h01);
    run_idle();

    // Stack overflow on the fifth nested CALL.
    clear_rom();
    rom[0] = uw(4, 8'h20, 0, 0);
    for (int k = 8'h20; k <= 8'h23; k++) rom[k] = uw(4, k + 1, 0, 0);
    start();
    for (int k = 0; k < 5; k++) begin
      step(1'b0);
      check("nest_done", if8.DONE, 0);
    end
    check("nest_err", if8.STACK_ERR, 1);
    check("nest_busy", if8.BUSY, 0);

    // RET with empty stack, then GO clears the fault.
    clear_rom();
    rom[0] = uw(5, 0, 0, 0);
    start();
    check("go_clr_err", if8.STACK_ERR, 0);
    step(1'b0);
    check("ret0_err", if8.STACK_ERR, 1);
    check("ret0_busy", if16.BUSY, 0);
    start();
    check("go_clr_err2", if16.STACK_ERR, 0);
    run_idle();

    // JAM suppresses the current microword's datapath effects.
    clear_rom();
    rom[0] = uw(1, 8'h17, 0, LDA);
    rom[8'h17] = uw(0, 0, 10, AALU | LDOUT | UPD);
    rom[8'h30] = uw(0, 0, 0, LDOUT);
    a_in = 16'h0055;
    start(); step(1'b0);
    jam = 1'b1; opcode = 4'd3;
    step(1'b0);
    jam = 1'b0;
    check("jam_upc", if8.MICROADDRESS, 8'h30);
    check("jam_busy", if8.BUSY, 1);
    step(1'b0);
    check("jam_a_kept", if8.DATA_OUT, 8'h55);
    run_idle();

    // RESET wins over JAM.
    clear_rom();
    rom[0] = uw(1, 0, 2, AALU | LDOUT);
    start(); step(1'b0);
    jam = 1'b1;
    step(1'b1);
    jam = 1'b0;
    check("rstjam_upc", if8.MICROADDRESS, 0);
    check("rstjam_busy", if8.BUSY, 0);
    check("rstjam_out", if16.DATA_OUT, 0);

    // uPC wrap 0xFF -> 0x00.
    clear_rom();
    rom[0] = uw(1, 8'hFF, 0, 0);
    rom[8'hFF] = uw(0, 0, 0, 0);
    start(); step(1'b0);
    check("pre_wrap", if8.MICROADDRESS, 8'hFF);
    step(1'b0);
    check("wrap_upc", if8.MICROADDRESS, 8'h00);
    step(1'b1);

    // Random microprograms and host activity.
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) for (int k = 0; k < 256; k++) rom[k] = 24'($urandom);
      a_in   = 16'($urandom);
      b_in   = 16'($urandom);
      opcode = 4'($urandom);
      go     = ($urandom % 4 == 0);
      jam    = ($urandom % 40 == 0);
      step($urandom % 300 == 0);
    end
    go = 1'b0; jam = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
